ysyx_24080006_idu: RTL and testbench

Instruction decode unit of the multi-cycle RV32E core. It sits between the fetch stage (IFU) and the execute stage (EXU).
- Accepts one fetched instruction and its PC per valid/ready handshake.
- Reads both source operands from the register file in the same cycle.
- Decodes the instruction into registered control fields, immediate and operands, and holds them until EXU accepts.

---
 rtl/ysyx_24080006_idu.sv | 174 +++++++++++++++++
 tb/tb_ysyx_24080006_idu.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24080006_idu.sv
// RV32E instruction decode unit: one IFU handshake, registered bundle held until EXU accepts.
// Optional RV32M decode (funct7=0000001 -> MULDIV) is enabled by defining YSYX_24080006_RV32M_EN.
module ysyx_24080006_idu (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_valid,
  output logic        ifu_ready,
  input  logic [31:0] ifu_inst,
  input  logic [31:0] ifu_pc,
  output logic [3:0]  rf_raddr1,
  output logic [3:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic        exu_valid,
  input  logic        exu_ready,
  output logic [31:0] exu_pc,
  output logic [3:0]  exu_op,
  output logic [2:0]  exu_funct3,
  output logic        exu_alt,
  output logic [31:0] exu_imm,
  output logic [31:0] exu_rs1_data,
  output logic [31:0] exu_rs2_data,
  output logic [3:0]  exu_rd,
  output logic        exu_rd_wen
);

  typedef enum logic [3:0] {
    OP_ALU_REG = 4'd0,  OP_ALU_IMM = 4'd1, OP_LOAD   = 4'd2, OP_STORE = 4'd3,
    OP_BRANCH  = 4'd4,  OP_JAL     = 4'd5, OP_JALR   = 4'd6, OP_LUI   = 4'd7,
    OP_AUIPC   = 4'd8,  OP_SYSTEM  = 4'd9, OP_MULDIV = 4'd10, OP_ILLEGAL = 4'd15
  } op_e;

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_e;

  typedef struct packed {
    logic [31:0] pc;
    op_e         op;
    logic [2:0]  funct3;
    logic        alt;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [3:0]  rd;
    logic        rd_wen;
  } bundle_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  op_e         dec_op;
  logic [31:0] dec_imm;
  logic        dec_alt, dec_rd_wen;
  logic        use_rs1, use_rs2, use_rd;

  state_e  state_q, state_d;
  bundle_t bundle_q, bundle_d;

  assign opcode    = ifu_inst[6:0];
  assign funct3    = ifu_inst[14:12];
  assign funct7    = ifu_inst[31:25];
  assign rf_raddr1 = ifu_inst[18:15];
  assign rf_raddr2 = ifu_inst[23:20];

  assign imm_i = {{20{ifu_inst[31]}}, ifu_inst[31:20]};
  assign imm_s = {{20{ifu_inst[31]}}, ifu_inst[31:25], ifu_inst[11:7]};
  assign imm_b = {{19{ifu_inst[31]}}, ifu_inst[31], ifu_inst[7], ifu_inst[30:25], ifu_inst[11:8], 1'b0};
  assign imm_u = {ifu_inst[31:12], 12'b0};
  assign imm_j = {{11{ifu_inst[31]}}, ifu_inst[31], ifu_inst[19:12], ifu_inst[20], ifu_inst[30:21], 1'b0};

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    dec_op  = OP_ILLEGAL;
    dec_imm = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opcode)
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) dec_op = OP_ALU_REG;
`ifdef YSYX_24080006_RV32M_EN
        else if (funct7 == 7'b0000001) dec_op = OP_MULDIV;
`endif
      end
      OPC_OP_IMM: begin dec_op = OP_ALU_IMM; dec_imm = imm_i; use_rs1 = 1'b1; use_rd = 1'b1; end
      OPC_LOAD:   begin dec_op = OP_LOAD;    dec_imm = imm_i; use_rs1 = 1'b1; use_rd = 1'b1; end
      OPC_STORE:  begin dec_op = OP_STORE;   dec_imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_BRANCH: begin dec_op = OP_BRANCH;  dec_imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_JAL:    begin dec_op = OP_JAL;     dec_imm = imm_j; use_rd = 1'b1; end
      OPC_JALR:   begin dec_op = OP_JALR;    dec_imm = imm_i; use_rs1 = 1'b1; use_rd = 1'b1; end
      OPC_LUI:    begin dec_op = OP_LUI;     dec_imm = imm_u; use_rd = 1'b1; end
      OPC_AUIPC:  begin dec_op = OP_AUIPC;   dec_imm = imm_u; use_rd = 1'b1; end
      OPC_SYSTEM: begin
        // CSR forms name rd; only csrrw/csrrs/csrrc use rs1 as a register (the rest carry a uimm).
        dec_op  = OP_SYSTEM;
        dec_imm = {20'b0, ifu_inst[31:20]};
        use_rd  = (funct3 != 3'b000);
        use_rs1 = (funct3 != 3'b000) && !funct3[2];
      end
      default: ;
    endcase

    // RV32E has only x0..x15, so bit 4 of any register field in use is illegal.
    if ((use_rs1 && ifu_inst[19]) || (use_rs2 && ifu_inst[24]) || (use_rd && ifu_inst[11]))
      dec_op = OP_ILLEGAL;
    if (dec_op == OP_ILLEGAL) dec_imm = '0;

    dec_alt    = (dec_op == OP_ALU_IMM && funct3 != 3'b101) ? 1'b0 : ifu_inst[30];
    dec_rd_wen = (ifu_inst[11:7] != 5'd0) &&
                 (dec_op inside {OP_ALU_REG, OP_ALU_IMM, OP_LOAD, OP_JAL, OP_JALR,
                                 OP_LUI, OP_AUIPC, OP_MULDIV});
  end

  always_comb begin
    state_d  = state_q;
    bundle_d = bundle_q;
    case (state_q)
      S_IDLE: begin
        if (ifu_valid) begin
          state_d           = S_HOLD;
          bundle_d.pc       = ifu_pc;
          bundle_d.op       = dec_op;
          bundle_d.funct3   = funct3;
          bundle_d.alt      = dec_alt;
          bundle_d.imm      = dec_imm;
          bundle_d.rs1_data = rf_rdata1;
          bundle_d.rs2_data = rf_rdata2;
          bundle_d.rd       = ifu_inst[10:7];
          bundle_d.rd_wen   = dec_rd_wen;
        end
      end
      S_HOLD:  if (exu_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset here is synchronous and active-high.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      bundle_q <= '0;
    end else begin
      state_q  <= state_d;
      bundle_q <= bundle_d;
    end
  end

  assign ifu_ready    = (state_q == S_IDLE);
  assign exu_valid    = (state_q == S_HOLD);
  assign exu_pc       = bundle_q.pc;
  assign exu_op       = bundle_q.op;
  assign exu_funct3   = bundle_q.funct3;
  assign exu_alt      = bundle_q.alt;
  assign exu_imm      = bundle_q.imm;
  assign exu_rs1_data = bundle_q.rs1_data;
  assign exu_rs2_data = bundle_q.rs2_data;
  assign exu_rd       = bundle_q.rd;
  assign exu_rd_wen   = bundle_q.rd_wen;

endmodule

// File: tb/tb_ysyx_24080006_idu.sv
// Self-checking bench for ysyx_24080006_idu: directed cases then randomized traffic vs a decode model.
module tb_ysyx_24080006_idu;

  logic        clock = 1'b0;
  logic        reset, ifu_valid, ifu_ready, exu_valid, exu_ready, exu_alt, exu_rd_wen;
  logic [31:0] ifu_inst, ifu_pc, rf_rdata1, rf_rdata2;
  logic [31:0] exu_pc, exu_imm, exu_rs1_data, exu_rs2_data;
  logic [3:0]  rf_raddr1, rf_raddr2, exu_op, exu_rd;
  logic [2:0]  exu_funct3;
  logic [31:0] regs [16];

  int n_tests = 0;
  int n_fail  = 0;

`ifdef YSYX_24080006_RV32M_EN
  localparam bit RV32M = 1'b1;
`else
  localparam bit RV32M = 1'b0;
`endif

  always #5 clock = ~clock;

  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];

  ysyx_24080006_idu dut (
    .clock(clock), .reset(reset),
    .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .ifu_inst(ifu_inst), .ifu_pc(ifu_pc),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_pc(exu_pc), .exu_op(exu_op),
    .exu_funct3(exu_funct3), .exu_alt(exu_alt), .exu_imm(exu_imm),
    .exu_rs1_data(exu_rs1_data), .exu_rs2_data(exu_rs2_data),
    .exu_rd(exu_rd), .exu_rd_wen(exu_rd_wen)
  );

  typedef struct {
    logic [31:0] pc, imm, rs1, rs2;
    logic [3:0]  op, rd;
    logic [2:0]  f3;
    logic        alt, wen;
  } exp_t;

  exp_t exp_b;
  bit   exp_hold, exp_fresh;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Decode straight from the ISA tables: opcode -> class, operand usage, immediate by shifting fields.
  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int cls;
    bit n1, n2, nd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] hi20, hi25, sgn;
    f3   = inst[14:12];
    f7   = inst[31:25];
    hi20 = $signed(inst) >>> 20;
    hi25 = $signed(inst) >>> 25;
    sgn  = $signed(inst) >>> 31;
    n1 = 0; n2 = 0; nd = 0; cls = 15;
    e.imm = 32'd0;
    case (inst[6:0])
      7'b0110011: begin
        n1 = 1; n2 = 1; nd = 1;
        if (f7 == 7'd0 || f7 == 7'h20) cls = 0;
        else if (f7 == 7'd1 && RV32M) cls = 10;
      end
      7'b0010011: begin cls = 1; n1 = 1; nd = 1; e.imm = hi20; end
      7'b0000011: begin cls = 2; n1 = 1; nd = 1; e.imm = hi20; end
      7'b0100011: begin cls = 3; n1 = 1; n2 = 1; e.imm = (hi25 << 5) | 32'(inst[11:7]); end
      7'b1100011: begin
        cls = 4; n1 = 1; n2 = 1;
        e.imm = (sgn << 12) | (32'(inst[7]) << 11) | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
      end
      7'b1101111: begin
        cls = 5; nd = 1;
        e.imm = (sgn << 20) | (32'(inst[19:12]) << 12) | (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
      end
      7'b1100111: begin cls = 6; n1 = 1; nd = 1; e.imm = hi20; end
      7'b0110111: begin cls = 7; nd = 1; e.imm = inst & 32'hFFFF_F000; end
      7'b0010111: begin cls = 8; nd = 1; e.imm = inst & 32'hFFFF_F000; end
      7'b1110011: begin
        cls = 9; e.imm = inst >> 20;
        nd = (f3 != 3'd0);
        n1 = (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3);
      end
      default: cls = 15;
    endcase
    if ((n1 && inst[19]) || (n2 && inst[24]) || (nd && inst[11])) cls = 15;
    if (cls == 15) e.imm = 32'd0;
    e.op  = 4'(cls);
    e.f3  = f3;
    e.alt = (cls == 1 && f3 != 3'b101) ? 1'b0 : inst[30];
    e.wen = (cls inside {0, 1, 2, 5, 6, 7, 8, 10}) && (inst[11:7] != 5'd0);
    e.rd  = inst[10:7];
    e.pc  = pc;
    e.rs1 = a;
    e.rs2 = b;
    return e;
  endfunction

  task automatic check_all();
    check("ifu_ready", 32'(ifu_ready), 32'(!exp_hold));
    check("exu_valid", 32'(exu_valid), 32'(exp_hold));
    check("rf_raddr1", 32'(rf_raddr1), 32'(ifu_inst[18:15]));
    check("rf_raddr2", 32'(rf_raddr2), 32'(ifu_inst[23:20]));
    if (exp_hold || exp_fresh) begin
      check("exu_pc",     exu_pc,            exp_b.pc);
      check("exu_op",     32'(exu_op),       32'(exp_b.op));
      check("exu_funct3", 32'(exu_funct3),   32'(exp_b.f3));
      check("exu_alt",    32'(exu_alt),      32'(exp_b.alt));
      check("exu_imm",    exu_imm,           exp_b.imm);
      check("exu_rs1",    exu_rs1_data,      exp_b.rs1);
      check("exu_rs2",    exu_rs2_data,      exp_b.rs2);
      check("exu_rd",     32'(exu_rd),       32'(exp_b.rd));
      check("exu_rd_wen", 32'(exu_rd_wen),   32'(exp_b.wen));
    end
  endtask

  // Advance the model with the inputs currently driven, clock once, then compare at the falling edge.
  task automatic cycle();
    if (reset) begin
      exp_hold  = 0;
      exp_fresh = 1;
      exp_b     = '{default: 0};
    end else if (!exp_hold && ifu_valid) begin
      exp_b     = model(ifu_inst, ifu_pc, regs[ifu_inst[18:15]], regs[ifu_inst[23:20]]);
      exp_hold  = 1;
      exp_fresh = 0;
    end else if (exp_hold && exu_ready) begin
      exp_hold = 0;
    end
    @(posedge clock);
    @(negedge clock);
    check_all();
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    ifu_valid = 1'b1;
    ifu_inst  = inst;
    ifu_pc    = pc;
    exu_ready = 1'b0;
    cycle();
    ifu_valid = 1'b0;
  endtask

  task automatic release_bundle();
    exu_ready = 1'b1;
    cycle();
    exu_ready = 1'b0;
  endtask

  function automatic logic [31:0] gen_inst();
    logic [31:0] w;
    logic [6:0]  opcs [11];
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h73, 7'h33};
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = opcs[$urandom_range(0, 10)];
    if (w[6:0] == 7'h33) begin
      case ($urandom_range(0, 3))
        0:       w[31:25] = 7'h00;
        1:       w[31:25] = 7'h20;
        2:       w[31:25] = 7'h01;
        default: ;
      endcase
    end
    if ($urandom_range(0, 3) != 0) begin
      w[11] = 1'b0;
      w[19] = 1'b0;
      w[24] = 1'b0;
    end
    if (w[6:0] == 7'h73 && $urandom_range(0, 1) == 1) w[14:12] = 3'd0;
    return w;
  endfunction

  initial begin
    reset     = 1'b1;
    ifu_valid = 1'b0;
    exu_ready = 1'b0;
    ifu_inst  = 32'd0;
    ifu_pc    = 32'd0;
    for (int i = 0; i < 16; i++) regs[i] = 32'd0;
    exp_hold  = 0;
    exp_fresh = 1;
    exp_b     = '{default: 0};

    // Reset held two cycles, then idle.
    cycle();
    cycle();
    check("rst_ifu_ready", 32'(ifu_ready), 32'd1);
    check("rst_exu_valid", 32'(exu_valid), 32'd0);
    check("rst_exu_imm",   exu_imm,        32'd0);
    reset = 1'b0;
    cycle();

    // addi x1,x0,5
    issue(32'h0050_0093, 32'h8000_0000);
    check("addi_valid", 32'(exu_valid),  32'd1);
    check("addi_op",    32'(exu_op),     32'd1);
    check("addi_imm",   exu_imm,         32'd5);
    check("addi_rd",    32'(exu_rd),     32'd1);
    check("addi_wen",   32'(exu_rd_wen), 32'd1);
    check("addi_alt",   32'(exu_alt),    32'd0);
    check("addi_pc",    exu_pc,          32'h8000_0000);
    release_bundle();

    // lw x2,-4(x1), EXU stalls three cycles.
    regs[1] = 32'h8000_1000;
    issue(32'hFFC0_A103, 32'h8000_0004);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("lw_ready", 32'(ifu_ready), 32'd0);
      check("lw_op",    32'(exu_op),    32'd2);
      check("lw_imm",   exu_imm,        32'hFFFF_FFFC);
      check("lw_rs1",   exu_rs1_data,   32'h8000_1000);
    end
    release_bundle();
    check("lw_ready_after", 32'(ifu_ready), 32'd1);

    // add x16,x0,x0: rd out of RV32E range.
    issue(32'h0000_0833, 32'h8000_0008);
    check("x16_op",  32'(exu_op),     32'd15);
    check("x16_wen", 32'(exu_rd_wen), 32'd0);
    release_bundle();

    // ebreak
    issue(32'h0010_0073, 32'h8000_000C);
    check("ebreak_op",  32'(exu_op),     32'd9);
    check("ebreak_imm", exu_imm,         32'd1);
    check("ebreak_wen", 32'(exu_rd_wen), 32'd0);
    release_bundle();

    // mul x3,x1,x2
    issue(32'h0220_81B3, 32'h8000_0010);
    check("mul_op",  32'(exu_op),     RV32M ? 32'd10 : 32'd15);
    check("mul_wen", 32'(exu_rd_wen), RV32M ? 32'd1 : 32'd0);
    check("mul_f3",  32'(exu_funct3), 32'd0);
    check("mul_rd",  32'(exu_rd),     32'd3);
    release_bundle();

    // Reset one cycle after a handshake drops the pending bundle.
    issue(32'h0050_0093, 32'h8000_0014);
    reset = 1'b1;
    cycle();
    check("midrst_valid", 32'(exu_valid), 32'd0);
    check("midrst_ready", 32'(ifu_ready), 32'd1);
    reset = 1'b0;
    cycle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 299) == 0);
      ifu_valid = ($urandom_range(0, 9) < 7);
      exu_ready = ($urandom_range(0, 1) == 1);
      ifu_inst  = gen_inst();
      ifu_pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      for (int i = 1; i < 16; i++) regs[i] = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
